vcve2_wb_stage: RTL and testbench
=================================

Name: vcve2_wb_stage

Overview:
- Parametrised writeback stage, the successor to the scalar passthrough writeback. Sits between ID/EX + LSU and the scalar RF / vector RF.
- Scalar path: configurable as passthrough or one registered writeback stage. Perf-retire outputs stay aligned with the RF write.
- Vector path: writes VLEN-wide registers. Whole-register ID results are registered; vector loads arrive as XLEN-bit LSU beats that are assembled and committed in a single VRF write.

Parameters:
- WritebackStage, 1, 1 = scalar RF write and perf outputs registered (latency 1); 0 = combinational passthrough (latency 0).
- XLEN, 32, scalar data and LSU beat width.
- VLEN, 128, vector register width. Must be an integer multiple of XLEN, with VLEN/XLEN >= 2.
- Derived: BEATS = VLEN/XLEN; CntW = $clog2(BEATS).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- en_wb_i  in  1  ID instruction completes this cycle
- instr_is_compressed_id_i  in  1  completing instruction is compressed
- instr_perf_count_id_i  in  1  completing instruction counts toward retire
- rf_waddr_id_i  in  5  scalar destination register
- rf_wdata_id_i  in  XLEN  scalar result from ID/EX
- rf_we_id_i  in  1  scalar write from ID/EX
- rf_wdata_lsu_i  in  XLEN  scalar load data
- rf_we_lsu_i  in  1  scalar load write
- lsu_resp_valid_i  in  1  LSU response valid
- lsu_resp_err_i  in  1  LSU response error
- rf_waddr_wb_o  out  5  scalar RF write address
- rf_wdata_wb_o  out  XLEN  scalar RF write data
- rf_we_wb_o  out  1  scalar RF write enable
- perf_instr_ret_wb_o  out  1  instruction retired
- perf_instr_ret_compressed_wb_o  out  1  compressed instruction retired
- vrf_we_id_i  in  1  whole-register vector write request from ID
- vrf_waddr_id_i  in  5  vector destination; also sampled on load start
- vrf_wdata_id_i  in  VLEN  vector result from ID/EX
- vrf_ld_start_i  in  1  vector load begins; destination taken from vrf_waddr_id_i
- vrf_is_mem_i  in  1  current LSU response belongs to a vector load
- vrf_wdata_lsu_i  in  XLEN  vector load beat
- vrf_id_ready_o  out  1  vector ID write and load start accepted this cycle
- vrf_ld_busy_o  out  1  vector load in progress
- vrf_ld_err_o  out  1  one-cycle pulse: vector load aborted on error
- vrf_we_wb_o  out  1  VRF write enable
- vrf_waddr_wb_o  out  5  VRF write address
- vrf_wdata_wb_o  out  VLEN  VRF write data

Behaviour:
- Reset (async, rst_i=1): all registered outputs 0, FSM to V_IDLE, beat counter 0, assembly buffer 0. Reset mid-load discards the partial load with no VRF write and no error pulse.
- Scalar data select: data = (rf_we_id_i ? rf_wdata_id_i : 0) | (rf_we_lsu_i ? rf_wdata_lsu_i : 0). Write enable = rf_we_id_i | rf_we_lsu_i. Address = rf_waddr_id_i.
- Scalar one-source rule: assert $onehot0({rf_we_id_i, rf_we_lsu_i}).
- Retire: ret = instr_perf_count_id_i & en_wb_i & ~(lsu_resp_valid_i & lsu_resp_err_i). Compressed retire = ret & instr_is_compressed_id_i.
- WritebackStage=1: scalar enable, address, data and both perf outputs are flopped and appear exactly 1 cycle after the inputs.
- WritebackStage=0: scalar enable, address, data and both perf outputs are driven combinationally from the inputs.
- Vector FSM states: V_IDLE, V_COLLECT, V_COMMIT.
- vrf_id_ready_o = (state == V_IDLE). vrf_ld_busy_o = (state != V_IDLE).
- V_IDLE, vector ID write: if vrf_we_id_i & en_wb_i, capture address and data. Next cycle vrf_we_wb_o=1 with that address and vrf_wdata_id_i.
- V_IDLE, load start: if vrf_ld_start_i, latch vrf_waddr_id_i, clear the counter, go to V_COLLECT.
- V_IDLE, both in one cycle: an ID write and a load start are both accepted; the ID write emits next cycle.
- V_IDLE, stray beats: LSU beats are ignored, including in the start cycle.
- V_COLLECT, beat: a beat is lsu_resp_valid_i & vrf_is_mem_i. A good beat stores vrf_wdata_lsu_i into slot cnt (slot k = bits [k*XLEN +: XLEN]; beat 0 is the LSB) and increments cnt.
- V_COLLECT, last beat (cnt == BEATS-1): store it, go to V_COMMIT.
- V_COLLECT, error beat: do not store it, pulse vrf_ld_err_o next cycle, go to V_IDLE, no VRF write.
- V_COLLECT, blocked requests: vrf_we_id_i and vrf_ld_start_i are not accepted. The requester holds them until ready.
- V_COMMIT: vrf_we_wb_o=1 for exactly 1 cycle with the latched address and the full buffer, then go to V_IDLE.
- vrf_we_wb_o is 0 in every other cycle.
- Vector load latency: commit appears 1 cycle after the last beat.
- An ID write accepted in the load-start cycle can never collide with a commit, because BEATS >= 2.

Test Plan:
- Reset, then WritebackStage=1: rf_we_id_i=1, waddr=5, wdata=0xDEADBEEF, en_wb_i=1, perf=1 -> next cycle rf_we_wb_o=1, addr 5, data 0xDEADBEEF, perf_instr_ret_wb_o=1. With WritebackStage=0 the same outputs appear the same cycle.
- Scalar load with lsu_resp_valid_i=1, lsu_resp_err_i=1, en_wb_i=1, perf=1, compressed=1 -> both perf outputs 0. With err=0 -> perf_instr_ret_wb_o=1 and perf_instr_ret_compressed_wb_o=1.
- VLEN=128: vrf_ld_start_i with waddr=3, then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with one idle cycle between beats 2 and 3 -> one vrf_we_wb_o pulse the cycle after the last beat, addr 3, data 0x44444444_33333333_22222222_11111111. vrf_ld_busy_o is high from the cycle after start until the commit cycle.
- Vector load with an error on beat 2 -> vrf_ld_err_o pulses 1 cycle, no vrf_we_wb_o, vrf_id_ready_o returns to 1. A subsequent clean load commits correct data with no stale slots.
- vrf_we_id_i during V_COLLECT -> vrf_id_ready_o=0 and no write. Same-cycle vrf_we_id_i and vrf_ld_start_i in V_IDLE -> ID write emitted next cycle and load commits later.
- Assert rst_i after 2 of 4 beats -> all outputs 0, no commit. A new load after reset completes normally.

Source files
------------

// File: rtl/vcve2_wb_stage.sv
// Writeback stage: scalar RF write (registered or passthrough) with aligned retire strobes,
// plus a vector path committing whole-register ID results and assembled LSU load beats.
module vcve2_wb_stage #(
  parameter bit          WritebackStage = 1'b1,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned VLEN           = 128
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_wb_i,
  input  logic            instr_is_compressed_id_i,
  input  logic            instr_perf_count_id_i,
  input  logic [4:0]      rf_waddr_id_i,
  input  logic [XLEN-1:0] rf_wdata_id_i,
  input  logic            rf_we_id_i,
  input  logic [XLEN-1:0] rf_wdata_lsu_i,
  input  logic            rf_we_lsu_i,
  input  logic            lsu_resp_valid_i,
  input  logic            lsu_resp_err_i,
  output logic [4:0]      rf_waddr_wb_o,
  output logic [XLEN-1:0] rf_wdata_wb_o,
  output logic            rf_we_wb_o,
  output logic            perf_instr_ret_wb_o,
  output logic            perf_instr_ret_compressed_wb_o,
  input  logic            vrf_we_id_i,
  input  logic [4:0]      vrf_waddr_id_i,
  input  logic [VLEN-1:0] vrf_wdata_id_i,
  input  logic            vrf_ld_start_i,
  input  logic            vrf_is_mem_i,
  input  logic [XLEN-1:0] vrf_wdata_lsu_i,
  output logic            vrf_id_ready_o,
  output logic            vrf_ld_busy_o,
  output logic            vrf_ld_err_o,
  output logic            vrf_we_wb_o,
  output logic [4:0]      vrf_waddr_wb_o,
  output logic [VLEN-1:0] vrf_wdata_wb_o
);

  localparam int unsigned     BEATS    = VLEN / XLEN;
  localparam int unsigned     CntW     = $clog2(BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  logic [XLEN-1:0] rf_wdata;
  logic            rf_we;
  logic            instr_ret;
  logic            instr_ret_c;

  // Only one scalar source writes per cycle, so OR-ing the gated sources is a mux.
  always_comb begin
    rf_wdata    = (rf_we_id_i ? rf_wdata_id_i : '0) | (rf_we_lsu_i ? rf_wdata_lsu_i : '0);
    rf_we       = rf_we_id_i | rf_we_lsu_i;
    instr_ret   = instr_perf_count_id_i & en_wb_i & ~(lsu_resp_valid_i & lsu_resp_err_i);
    instr_ret_c = instr_ret & instr_is_compressed_id_i;
  end

  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0({rf_we_id_i, rf_we_lsu_i}));

  generate
    if (WritebackStage) begin : g_wb_reg
      logic [4:0]      rf_waddr_q;
      logic [XLEN-1:0] rf_wdata_q;
      logic            rf_we_q;
      logic            ret_q;
      logic            ret_c_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rf_waddr_q <= '0;
          rf_wdata_q <= '0;
          rf_we_q    <= 1'b0;
          ret_q      <= 1'b0;
          ret_c_q    <= 1'b0;
        end else begin
          rf_waddr_q <= rf_waddr_id_i;
          rf_wdata_q <= rf_wdata;
          rf_we_q    <= rf_we;
          ret_q      <= instr_ret;
          ret_c_q    <= instr_ret_c;
        end
      end

      assign rf_waddr_wb_o                  = rf_waddr_q;
      assign rf_wdata_wb_o                  = rf_wdata_q;
      assign rf_we_wb_o                     = rf_we_q;
      assign perf_instr_ret_wb_o            = ret_q;
      assign perf_instr_ret_compressed_wb_o = ret_c_q;
    end else begin : g_wb_pass
      assign rf_waddr_wb_o                  = rf_waddr_id_i;
      assign rf_wdata_wb_o                  = rf_wdata;
      assign rf_we_wb_o                     = rf_we;
      assign perf_instr_ret_wb_o            = instr_ret;
      assign perf_instr_ret_compressed_wb_o = instr_ret_c;
    end
  endgenerate

  typedef enum logic [1:0] {V_IDLE, V_COLLECT, V_COMMIT} vstate_e;

  vstate_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [VLEN-1:0] buf_q, buf_d;
  logic [4:0]      ld_addr_q, ld_addr_d;
  logic            err_q, err_d;
  logic            id_we_q, id_we_d;
  logic [4:0]      id_addr_q, id_addr_d;
  logic [VLEN-1:0] id_data_q, id_data_d;
  logic            ld_beat;
  logic            id_ready;
  logic            commit;

  assign ld_beat = lsu_resp_valid_i & vrf_is_mem_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= V_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      V_IDLE: begin
        if (vrf_ld_start_i) state_d = V_COLLECT;
      end
      V_COLLECT: begin
        if (ld_beat) begin
          if (lsu_resp_err_i)          state_d = V_IDLE;
          else if (cnt_q == LastBeat)  state_d = V_COMMIT;
        end
      end
      V_COMMIT: state_d = V_IDLE;
      default:  state_d = V_IDLE;
    endcase
  end

  always_comb begin
    id_ready = (state_q == V_IDLE);
    commit   = (state_q == V_COMMIT);
  end

  // Buffer is cleared on load start so an aborted load never leaks into the next one.
  always_comb begin
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    ld_addr_d = ld_addr_q;
    err_d     = 1'b0;
    id_we_d   = id_ready & vrf_we_id_i & en_wb_i;
    id_addr_d = id_addr_q;
    id_data_d = id_data_q;
    if (id_we_d) begin
      id_addr_d = vrf_waddr_id_i;
      id_data_d = vrf_wdata_id_i;
    end
    if (id_ready && vrf_ld_start_i) begin
      cnt_d     = '0;
      buf_d     = '0;
      ld_addr_d = vrf_waddr_id_i;
    end
    if ((state_q == V_COLLECT) && ld_beat) begin
      if (lsu_resp_err_i) begin
        err_d = 1'b1;
      end else begin
        buf_d[cnt_q*XLEN +: XLEN] = vrf_wdata_lsu_i;
        cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      buf_q     <= '0;
      ld_addr_q <= '0;
      err_q     <= 1'b0;
      id_we_q   <= 1'b0;
      id_addr_q <= '0;
      id_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      ld_addr_q <= ld_addr_d;
      err_q     <= err_d;
      id_we_q   <= id_we_d;
      id_addr_q <= id_addr_d;
      id_data_q <= id_data_d;
    end
  end

  // ID writes are only accepted in V_IDLE, so they never overlap a V_COMMIT cycle.
  assign vrf_id_ready_o = id_ready;
  assign vrf_ld_busy_o  = ~id_ready;
  assign vrf_ld_err_o   = err_q;
  assign vrf_we_wb_o    = id_we_q | commit;
  assign vrf_waddr_wb_o = commit ? ld_addr_q : id_addr_q;
  assign vrf_wdata_wb_o = commit ? buf_q : id_data_q;

endmodule

// File: tb/tb_vcve2_wb_stage.sv
// Scoreboard bench for vcve2_wb_stage: a registered and a passthrough instance share stimulus;
// expected writes are queued by the stimulus and popped by per-instance monitors.
module tb_vcve2_wb_stage;

  localparam int XLEN = 32;
  localparam int VLEN = 128;

  typedef struct packed {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
    logic            r;
    logic            c;
  } sexp_t;

  typedef struct packed {
    logic [4:0]      a;
    logic [VLEN-1:0] d;
  } vexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            en_wb_i, instr_is_compressed_id_i, instr_perf_count_id_i;
  logic [4:0]      rf_waddr_id_i;
  logic [XLEN-1:0] rf_wdata_id_i, rf_wdata_lsu_i, vrf_wdata_lsu_i;
  logic            rf_we_id_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i;
  logic            vrf_we_id_i, vrf_ld_start_i, vrf_is_mem_i;
  logic [4:0]      vrf_waddr_id_i;
  logic [VLEN-1:0] vrf_wdata_id_i;

  logic [4:0]      rfWaddr1, rfWaddr0, vWaddr1, vWaddr0;
  logic [XLEN-1:0] rfWdata1, rfWdata0;
  logic [VLEN-1:0] vWdata1, vWdata0;
  logic            rfWe1, rfWe0, ret1, ret0, retC1, retC0;
  logic            vReady1, vReady0, vBusy1, vBusy0, vErr1, vErr0, vWe1, vWe0;

  int errors = 0;
  int checks = 0;

  sexp_t sq1[$];
  sexp_t sq0[$];
  vexp_t vq1[$];
  vexp_t vq0[$];
  bit    eq1[$];
  bit    eq0[$];
  sexp_t se1, se0;
  vexp_t ve1, ve0;

  vcve2_wb_stage #(.WritebackStage(1'b1), .XLEN(XLEN), .VLEN(VLEN)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_wb_i(en_wb_i),
    .instr_is_compressed_id_i(instr_is_compressed_id_i),
    .instr_perf_count_id_i(instr_perf_count_id_i),
    .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
    .rf_wdata_lsu_i(rf_wdata_lsu_i), .rf_we_lsu_i(rf_we_lsu_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .rf_waddr_wb_o(rfWaddr1), .rf_wdata_wb_o(rfWdata1), .rf_we_wb_o(rfWe1),
    .perf_instr_ret_wb_o(ret1), .perf_instr_ret_compressed_wb_o(retC1),
    .vrf_we_id_i(vrf_we_id_i), .vrf_waddr_id_i(vrf_waddr_id_i), .vrf_wdata_id_i(vrf_wdata_id_i),
    .vrf_ld_start_i(vrf_ld_start_i), .vrf_is_mem_i(vrf_is_mem_i), .vrf_wdata_lsu_i(vrf_wdata_lsu_i),
    .vrf_id_ready_o(vReady1), .vrf_ld_busy_o(vBusy1), .vrf_ld_err_o(vErr1),
    .vrf_we_wb_o(vWe1), .vrf_waddr_wb_o(vWaddr1), .vrf_wdata_wb_o(vWdata1)
  );

  vcve2_wb_stage #(.WritebackStage(1'b0), .XLEN(XLEN), .VLEN(VLEN)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_wb_i(en_wb_i),
    .instr_is_compressed_id_i(instr_is_compressed_id_i),
    .instr_perf_count_id_i(instr_perf_count_id_i),
    .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
    .rf_wdata_lsu_i(rf_wdata_lsu_i), .rf_we_lsu_i(rf_we_lsu_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .rf_waddr_wb_o(rfWaddr0), .rf_wdata_wb_o(rfWdata0), .rf_we_wb_o(rfWe0),
    .perf_instr_ret_wb_o(ret0), .perf_instr_ret_compressed_wb_o(retC0),
    .vrf_we_id_i(vrf_we_id_i), .vrf_waddr_id_i(vrf_waddr_id_i), .vrf_wdata_id_i(vrf_wdata_id_i),
    .vrf_ld_start_i(vrf_ld_start_i), .vrf_is_mem_i(vrf_is_mem_i), .vrf_wdata_lsu_i(vrf_wdata_lsu_i),
    .vrf_id_ready_o(vReady0), .vrf_ld_busy_o(vBusy0), .vrf_ld_err_o(vErr0),
    .vrf_we_wb_o(vWe0), .vrf_waddr_wb_o(vWaddr0), .vrf_wdata_wb_o(vWdata0)
  );

  task automatic checkOutput(input string name, input logic [VLEN-1:0] act,
                             input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    en_wb_i = 1'b0; instr_is_compressed_id_i = 1'b0; instr_perf_count_id_i = 1'b0;
    rf_waddr_id_i = '0; rf_wdata_id_i = '0; rf_we_id_i = 1'b0;
    rf_wdata_lsu_i = '0; rf_we_lsu_i = 1'b0; lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0;
    vrf_we_id_i = 1'b0; vrf_waddr_id_i = '0; vrf_wdata_id_i = '0;
    vrf_ld_start_i = 1'b0; vrf_is_mem_i = 1'b0; vrf_wdata_lsu_i = '0;
  endtask

  // One scalar cycle; expected values are hand-computed by the caller.
  task automatic applyStimulus(input logic weId, weLsu, input logic [4:0] addr,
                               input logic [XLEN-1:0] dId, dLsu,
                               input logic en, perf, comp, lValid, lErr,
                               input logic [XLEN-1:0] expData, input logic expRet, expComp,
                               input bit checkLat);
    idleInputs();
    rf_we_id_i = weId; rf_we_lsu_i = weLsu; rf_waddr_id_i = addr;
    rf_wdata_id_i = dId; rf_wdata_lsu_i = dLsu; en_wb_i = en;
    instr_perf_count_id_i = perf; instr_is_compressed_id_i = comp;
    lsu_resp_valid_i = lValid; lsu_resp_err_i = lErr;
    sq1.push_back('{a: addr, d: expData, r: expRet, c: expComp});
    sq0.push_back('{a: addr, d: expData, r: expRet, c: expComp});
    if (checkLat) begin
      @(negedge clk);
      checkOutput("wbLatency", rfWe1, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic vecCycle(input logic weId, ldStart, valid, isMem, err, input logic [4:0] addr,
                          input logic [VLEN-1:0] idData, input logic [XLEN-1:0] beat);
    idleInputs();
    vrf_we_id_i = weId; en_wb_i = weId; vrf_ld_start_i = ldStart;
    lsu_resp_valid_i = valid; vrf_is_mem_i = isMem; lsu_resp_err_i = err;
    vrf_waddr_id_i = addr; vrf_wdata_id_i = idData; vrf_wdata_lsu_i = beat;
    @(posedge clk); #1;
  endtask

  task automatic vStart(input logic [4:0] addr);
    vecCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, addr, '0, '0);
  endtask

  task automatic vBeat(input logic [XLEN-1:0] beat);
    vecCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, '0, beat);
  endtask

  task automatic vIdle();
    vecCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
  endtask

  task automatic vExpect(input logic [4:0] addr, input logic [VLEN-1:0] data);
    vq1.push_back('{a: addr, d: data});
    vq0.push_back('{a: addr, d: data});
  endtask

  task automatic checkVecCtl(input string name, input logic ready, busy, err, we);
    checkOutput({name, "Ready1"}, vReady1, ready);
    checkOutput({name, "Busy1"},  vBusy1,  busy);
    checkOutput({name, "Err1"},   vErr1,   err);
    checkOutput({name, "We1"},    vWe1,    we);
    checkOutput({name, "Ready0"}, vReady0, ready);
    checkOutput({name, "Busy0"},  vBusy0,  busy);
    checkOutput({name, "Err0"},   vErr0,   err);
    checkOutput({name, "We0"},    vWe0,    we);
  endtask

  always @(negedge clk) if (!rst && rfWe1) begin
    if (sq1.size() == 0) checkOutput("s1Spurious", rfWe1, 1'b0);
    else begin
      se1 = sq1.pop_front();
      checkOutput("s1Addr", rfWaddr1, se1.a);
      checkOutput("s1Data", rfWdata1, se1.d);
      checkOutput("s1Ret",  ret1,     se1.r);
      checkOutput("s1RetC", retC1,    se1.c);
    end
  end

  always @(negedge clk) if (!rst && rfWe0) begin
    if (sq0.size() == 0) checkOutput("s0Spurious", rfWe0, 1'b0);
    else begin
      se0 = sq0.pop_front();
      checkOutput("s0Addr", rfWaddr0, se0.a);
      checkOutput("s0Data", rfWdata0, se0.d);
      checkOutput("s0Ret",  ret0,     se0.r);
      checkOutput("s0RetC", retC0,    se0.c);
    end
  end

  always @(negedge clk) if (!rst && vWe1) begin
    if (vq1.size() == 0) checkOutput("v1Spurious", vWe1, 1'b0);
    else begin
      ve1 = vq1.pop_front();
      checkOutput("v1Addr", vWaddr1, ve1.a);
      checkOutput("v1Data", vWdata1, ve1.d);
    end
  end

  always @(negedge clk) if (!rst && vWe0) begin
    if (vq0.size() == 0) checkOutput("v0Spurious", vWe0, 1'b0);
    else begin
      ve0 = vq0.pop_front();
      checkOutput("v0Addr", vWaddr0, ve0.a);
      checkOutput("v0Data", vWdata0, ve0.d);
    end
  end

  always @(negedge clk) if (!rst && vErr1) begin
    if (eq1.size() == 0) checkOutput("e1Spurious", vErr1, 1'b0);
    else void'(eq1.pop_front());
  end

  always @(negedge clk) if (!rst && vErr0) begin
    if (eq0.size() == 0) checkOutput("e0Spurious", vErr0, 1'b0);
    else void'(eq0.pop_front());
  end

  initial begin
    idleInputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstRfWe1",   rfWe1,    1'b0);
    checkOutput("rstRfAddr1", rfWaddr1, 5'd0);
    checkOutput("rstRfData1", rfWdata1, '0);
    checkOutput("rstRet1",    ret1,     1'b0);
    checkOutput("rstRetC1",   retC1,    1'b0);
    checkVecCtl("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Scalar writes and retire qualification
    applyStimulus(1, 0, 5'd5,  32'hDEADBEEF, 32'h0,        1, 1, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1);
    applyStimulus(0, 1, 5'd10, 32'hAAAAAAAA, 32'hCAFEF00D, 1, 1, 1, 1, 1, 32'hCAFEF00D, 0, 0, 0);
    applyStimulus(0, 1, 5'd10, 32'hAAAAAAAA, 32'hCAFEF00D, 1, 1, 1, 1, 0, 32'hCAFEF00D, 1, 1, 0);
    applyStimulus(1, 0, 5'd31, 32'h12345678, 32'h0,        1, 0, 1, 0, 0, 32'h12345678, 0, 0, 0);
    applyStimulus(1, 0, 5'd2,  32'h0F0F0F0F, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 32'h0F0F0F0F, 0, 0, 0);
    applyStimulus(1, 0, 5'd17, 32'h00000001, 32'h0,        1, 1, 1, 1, 0, 32'h00000001, 1, 1, 0);
    vIdle();
    vIdle();

    // Load with a gap between beats
    vStart(5'd3);
    checkVecCtl("aStart", 1'b0, 1'b1, 1'b0, 1'b0);
    vBeat(32'h11111111);
    vBeat(32'h22222222);
    vIdle();
    checkVecCtl("aGap", 1'b0, 1'b1, 1'b0, 1'b0);
    vBeat(32'h33333333);
    vExpect(5'd3, 128'h44444444_33333333_22222222_11111111);
    vBeat(32'h44444444);
    checkVecCtl("aCommit", 1'b0, 1'b1, 1'b0, 1'b1);
    vIdle();
    checkVecCtl("aDone", 1'b1, 1'b0, 1'b0, 1'b0);

    // Error on beat 2 aborts, then a clean load
    vStart(5'd4);
    vBeat(32'hA0A0A0A0);
    vBeat(32'hB0B0B0B0);
    eq1.push_back(1'b1);
    eq0.push_back(1'b1);
    vecCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, '0, 32'hDEAD0000);
    checkVecCtl("bErr", 1'b1, 1'b0, 1'b1, 1'b0);
    vIdle();
    checkVecCtl("bErrGone", 1'b1, 1'b0, 1'b0, 1'b0);
    vStart(5'd5);
    vBeat(32'h55555555);
    vBeat(32'h66666666);
    vBeat(32'h77777777);
    vExpect(5'd5, 128'h88888888_77777777_66666666_55555555);
    vBeat(32'h88888888);
    checkVecCtl("bCommit", 1'b0, 1'b1, 1'b0, 1'b1);
    vIdle();

    // ID write presented during collection is refused
    vStart(5'd8);
    vBeat(32'h00000001);
    vecCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, {VLEN{1'b1}}, '0);
    checkVecCtl("cBlocked", 1'b0, 1'b1, 1'b0, 1'b0);
    vBeat(32'h00000002);
    vBeat(32'h00000003);
    vExpect(5'd8, 128'h00000004_00000003_00000002_00000001);
    vBeat(32'h00000004);
    vIdle();

    // ID write and load start accepted together
    vExpect(5'd7, 128'h0123456789ABCDEF_FEDCBA9876543210);
    vecCycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 128'h0123456789ABCDEF_FEDCBA9876543210, '0);
    checkVecCtl("dBoth", 1'b0, 1'b1, 1'b0, 1'b1);
    vBeat(32'h000000A1);
    vBeat(32'h000000A2);
    vBeat(32'h000000A3);
    vExpect(5'd7, 128'h000000A4_000000A3_000000A2_000000A1);
    vBeat(32'h000000A4);
    vIdle();

    // Reset mid-load discards it; a fresh load completes
    vStart(5'd6);
    vBeat(32'hE1E1E1E1);
    vBeat(32'hE2E2E2E2);
    idleInputs();
    rst = 1'b1;
    #1;
    checkVecCtl("eRst", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("eRstRfWe1", rfWe1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    vStart(5'd9);
    vBeat(32'h91919191);
    vBeat(32'h92929292);
    vBeat(32'h93939393);
    vExpect(5'd9, 128'h94949494_93939393_92929292_91919191);
    vBeat(32'h94949494);
    checkVecCtl("eCommit", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) vIdle();

    checkOutput("sq1Drain", sq1.size(), 0);
    checkOutput("sq0Drain", sq0.size(), 0);
    checkOutput("vq1Drain", vq1.size(), 0);
    checkOutput("vq0Drain", vq0.size(), 0);
    checkOutput("eq1Drain", eq1.size(), 0);
    checkOutput("eq0Drain", eq0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
